// File: rtl/fp_expander_if.sv
// Handshake bundle for fp_expander: float in (S/E/F), decoded linear value out (D).
// The slave modport is the decoder's view; master is the producer/consumer side.
interface fp_expander_if;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, out_valid, D
  );

  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, out_valid, D
  );
endinterface

// File: rtl/fp_expander.sv
// Decodes a tiny float (sign, 3-bit exponent, 4-bit significand) into a 12-bit
// two's-complement value by shifting one bit per cycle, then holds it for a handshake.
module fp_expander (
  input  logic         clk,
  input  logic         rst,
  fp_expander_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e      state_q, state_d;
  logic        s_q, s_d;
  logic [11:0] mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] d_q, d_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          s_d     = bus.S;
          mag_d   = {8'b0, bus.F};
          cnt_d   = bus.E;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != 3'd0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Negating zero wraps back to zero, so -0 needs no special case.
          d_d     = s_q ? (~mag_q + 12'd1) : mag_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= 1'b0;
      mag_q   <= 12'h000;
      cnt_q   <= 3'd0;
      d_q     <= 12'h000;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = (state_q == StHold);
  assign bus.D         = d_q;

endmodule

// File: doc/fp_expander.md
FP_EXPANDER -- requirements
Module: fp_expander

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  S/E/F present a float to decode.
REQ-005 in_ready  output  1  block can accept a float this cycle.
REQ-006 S  input  1  sign bit (1 = negative).
REQ-007 E  input  3  exponent, 0..7.
REQ-008 F  input  4  significand, unsigned, 0..15.
REQ-009 out_valid  output  1  D holds a decoded result.
REQ-010 out_ready  input  1  consumer takes D this cycle.
REQ-011 D  output  12  decoded two's-complement linear value.

Function
REQ-012 The block SHALL use three states: IDLE, SHIFT, HOLD.
REQ-013 in_ready SHALL be 1 only in IDLE with rst low, and 0 otherwise.
REQ-014 A transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
- On transfer: S latched; 12-bit magnitude register mag = {8'b0, F}; 3-bit counter cnt = E; state SHIFT.
REQ-015 S/E/F SHALL be ignored when no transfer occurs.
REQ-016 In SHIFT with cnt != 0, each edge SHALL do mag <= mag << 1 and cnt <= cnt - 1.
- One shift per cycle; no barrel shifter.
REQ-017 In SHIFT with cnt == 0, the edge SHALL load D and enter HOLD.
- D = S ? (~mag + 1) : mag, mod 2^12.
REQ-018 Width rule: the largest magnitude is 15<<7 = 1920, so D SHALL never overflow.
- Range of D is -1920..+1920.
REQ-019 Negative zero (S=1, F=0) SHALL decode to D = 12'h000.
REQ-020 out_valid SHALL be 1 exactly in HOLD.
REQ-021 D SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 In HOLD with out_ready=1, the edge SHALL return the block to IDLE and clear out_valid.
- D keeps its last value until the next load.
REQ-023 Latency: for a transfer on edge k, out_valid SHALL first be 1 after edge k+E+1.
REQ-024 Throughput: one result per E+3 cycles minimum; no overlap of transactions.
REQ-025 out_ready in IDLE or SHIFT SHALL have no effect.
REQ-026 in_valid outside IDLE SHALL have no effect; the upstream holds its data until in_ready.
REQ-027 All outputs except in_ready SHALL be registered.

Reset
REQ-028 On any edge with rst=1, the block SHALL set: state = IDLE, out_valid = 0, D = 12'h000, mag = 0, cnt = 0, S latch = 0.
REQ-029 rst SHALL take priority over every transfer and every shift.
- Reset in SHIFT or HOLD abandons the transaction; no result is produced.
REQ-030 On the first edge after rst falls, the block SHALL be able to accept a transfer.

Verification
REQ-031 The bench SHALL cover: S=0, E=0, F=9, out_ready=1 -> out_valid after edge k+1, D = 12'h009, then IDLE.
REQ-032 The bench SHALL cover: S=1, E=7, F=15 -> out_valid after edge k+8, D = 12'h880 (-1920).
REQ-033 The bench SHALL cover: S=0, E=3, F=5 with out_ready held 0 for 5 cycles.
- D = 12'h028 stable throughout; in_ready = 0 throughout; the next float is refused until the handshake.
REQ-034 The bench SHALL cover: S=1, E=2, F=0 -> D = 12'h000.
REQ-035 The bench SHALL cover: rst pulsed during SHIFT (E=6).
- out_valid never rises; D = 0; a float presented on the next cycle decodes correctly.
REQ-036 The bench SHALL cover an exhaustive sweep of all 256 {S, E, F} with random out_ready stalls.
- Each D must equal (-1)^S * F * 2^E.
- Each latency must equal E+1 edges to out_valid.
